// File: rtl/rgb_pkg.sv
// rgb_pkg: constants shared by the RGB PWM driver and its channel slices.
//   R_MSB/G_MSB/B_MSB : MSB of each 8-bit channel inside the 24-bit rgb word
//   DUTY_W            : duty-cycle width
//   DUTY_FULL         : duty code that forces a channel permanently on
package rgb_pkg;

    localparam int R_MSB  = 23;
    localparam int G_MSB  = 15;
    localparam int B_MSB  = 7;
    localparam int DUTY_W = 8;
    localparam int NUM_CH = 3;

    localparam logic [DUTY_W-1:0] DUTY_FULL = 8'hFF;

    // Per-channel duty view of a colour word, index 2=R, 1=G, 0=B.
    typedef logic [NUM_CH-1:0][DUTY_W-1:0] duty_vec_t;

    function automatic duty_vec_t split_rgb(input logic [23:0] c);
        duty_vec_t d;
        d[2] = c[R_MSB -: DUTY_W];
        d[1] = c[G_MSB -: DUTY_W];
        d[0] = c[B_MSB -: DUTY_W];
        return d;
    endfunction

endpackage

// File: rtl/pwm_channel.sv
// pwm_channel: one PWM output slice (compare plus output register).
//   clk, rst : system clock, synchronous active-high reset
//   cnt      : shared PWM counter
//   duty     : channel duty code
//   pwm      : registered PWM output
module pwm_channel
    import rgb_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [DUTY_W-1:0] cnt,
    input  logic [DUTY_W-1:0] duty,
    output logic              pwm
);

    // DUTY_FULL is special-cased: cnt < 255 alone would drop the output
    // for one step per period.
    always_ff @(posedge clk) begin
        if (rst) pwm <= 1'b0;
        else     pwm <= (duty == DUTY_FULL) || (cnt < duty);
    end

endmodule

// File: rtl/rgb_pwm_driver.sv
// rgb_pwm_driver: three-channel PWM LED driver with period-aligned colour
// updates.
//   PRESCALE            : clocks per PWM counter step (period = 256*PRESCALE)
//   clk, rst            : system clock, synchronous active-high reset
//   rgb, rgb_valid      : colour word and load strobe (no backpressure)
//   pwm_r, pwm_g, pwm_b : registered PWM outputs
//   period_start        : one-cycle pulse on the first clock of each period
//   pending             : a loaded colour is waiting for the next boundary
module rgb_pwm_driver
    import rgb_pkg::*;
#(
    parameter int PRESCALE = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] rgb,
    input  logic        rgb_valid,
    output logic        pwm_r,
    output logic        pwm_g,
    output logic        pwm_b,
    output logic        period_start,
    output logic        pending
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);

    logic [PW-1:0]     presc_cnt;
    logic [DUTY_W-1:0] pwm_cnt;
    logic [23:0]       active;
    logic [23:0]       pend_rgb;
    logic              pend_v;
    logic              tick;
    logic              boundary;
    duty_vec_t         duty;
    logic [NUM_CH-1:0] pwm;

    // With PRESCALE=1 the counter is stuck at 0 == PRESC_MAX, so tick is
    // permanently high.
    assign tick     = (presc_cnt == PRESC_MAX);
    assign boundary = tick && (pwm_cnt == 8'hFF);

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_cnt    <= '0;
            pwm_cnt      <= '0;
            active       <= '0;
            pend_rgb     <= '0;
            pend_v       <= 1'b0;
            period_start <= 1'b0;
        end else begin
            presc_cnt <= tick ? '0 : presc_cnt + 1'b1;
            if (tick) pwm_cnt <= pwm_cnt + 1'b1;

            // A load landing on the boundary goes straight to active so it
            // is not held back a whole period behind a stale shadow.
            if (boundary) begin
                if (rgb_valid)   active <= rgb;
                else if (pend_v) active <= pend_rgb;
                pend_v <= 1'b0;
            end else if (rgb_valid) begin
                pend_rgb <= rgb;
                pend_v   <= 1'b1;
            end

            period_start <= boundary;
        end
    end

    assign duty    = split_rgb(active);
    assign pending = pend_v;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        pwm_channel u_ch (
            .clk  (clk),
            .rst  (rst),
            .cnt  (pwm_cnt),
            .duty (duty[i]),
            .pwm  (pwm[i])
        );
    end

    assign pwm_r = pwm[2];
    assign pwm_g = pwm[1];
    assign pwm_b = pwm[0];

endmodule

// File: tb/tb_rgb_pwm_driver.sv
module tb_rgb_pwm_driver;

    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] rgb;
    logic        rgb_valid;
    logic        r1, g1, b1, ps1, pe1;
    logic        r4, g4, b4, ps4, pe4;

    // Both instances share stimulus; sel picks which one is observed.
    logic        sel;
    logic        pr, pg, pb, ps, pend;

    always #5 clk = ~clk;

    rgb_pwm_driver #(.PRESCALE(1)) dut1 (
        .clk(clk), .rst(rst), .rgb(rgb), .rgb_valid(rgb_valid),
        .pwm_r(r1), .pwm_g(g1), .pwm_b(b1), .period_start(ps1), .pending(pe1)
    );

    rgb_pwm_driver #(.PRESCALE(4)) dut4 (
        .clk(clk), .rst(rst), .rgb(rgb), .rgb_valid(rgb_valid),
        .pwm_r(r4), .pwm_g(g4), .pwm_b(b4), .period_start(ps4), .pending(pe4)
    );

    always_comb begin
        pr = sel ? r4 : r1;
        pg = sel ? g4 : g1;
        pb = sel ? b4 : b1;
        ps = sel ? ps4 : ps1;
        pend = sel ? pe4 : pe1;
    end

    typedef struct {
        logic [23:0] rgb;
        int          er, eg, eb;
    } vec_t;

    typedef struct {
        int    r, g, b;
        string tag;
    } exp_t;

    vec_t vecs[6];
    exp_t exp_q[$];
    int   n_chk = 0;
    int   n_pass = 0;
    int   last_pend;

    task automatic chk(input string name, input int act, input int expv);
        n_chk++;
        if (act == expv) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    endtask

    function automatic int hi_clocks(input logic [7:0] d, input int presc);
        return (d == 8'hFF) ? 256 * presc : int'(d) * presc;
    endfunction

    task automatic push_exp(input logic [23:0] c, input int presc, input string tag);
        exp_t e;
        e.r = hi_clocks(c[23:16], presc);
        e.g = hi_clocks(c[15:8], presc);
        e.b = hi_clocks(c[7:0], presc);
        e.tag = tag;
        exp_q.push_back(e);
    endtask

    task automatic wait_ps(input int maxc, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ps && n < maxc);
        if (!ps) chk("period_start_timeout", 0, 1);
    endtask

    // Called on a period_start sample; observes one whole period, optionally
    // loading colours at sample indices la/lb, then scores against the queue.
    task automatic measure(input int la, input logic [23:0] ra,
                           input int lb, input logic [23:0] rb);
        int n, cr, cg, cb, cps, first_g, last_ps;
        exp_t e;
        n = sel ? 1024 : 256;
        cr = 0; cg = 0; cb = 0; cps = 0; first_g = 0; last_ps = 0;
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            cr += int'(pr);
            cg += int'(pg);
            cb += int'(pb);
            cps += int'(ps);
            if (pg && first_g == 0) first_g = k;
            if (k == n) begin
                last_ps = int'(ps);
                last_pend = int'(pend);
            end
            if (k == la) begin
                rgb = ra; rgb_valid = 1'b1;
            end else if (k == lb) begin
                rgb = rb; rgb_valid = 1'b1;
            end else begin
                rgb_valid = 1'b0;
            end
        end
        rgb_valid = 1'b0;
        if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 0, 1);
            return;
        end
        e = exp_q.pop_front();
        chk({e.tag, "_r_high"}, cr, e.r);
        chk({e.tag, "_g_high"}, cg, e.g);
        chk({e.tag, "_b_high"}, cb, e.b);
        chk({e.tag, "_ps_count"}, cps, 1);
        chk({e.tag, "_ps_at_end"}, last_ps, 1);
        if (e.g > 0 && e.g < n) chk({e.tag, "_g_first_high"}, first_g, 1);
    endtask

    initial begin
        int w, hi, first_ps;

        vecs[0] = '{24'hFF0000, 256, 0, 0};
        vecs[1] = '{24'h008040, 0, 128, 64};
        vecs[2] = '{24'h0180FE, 1, 128, 254};
        vecs[3] = '{24'hFFFFFF, 256, 256, 256};
        vecs[4] = '{24'h000000, 0, 0, 0};
        vecs[5] = '{24'h008040, 0, 128, 64};

        sel = 1'b0;
        rst = 1'b1;
        rgb = '0;
        rgb_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outs_p1", int'({r1, g1, b1, ps1, pe1}), 0);
        chk("reset_outs_p4", int'({r4, g4, b4, ps4, pe4}), 0);
        rst = 1'b0;

        // Table: load mid-period, expect pending, then score the next period.
        foreach (vecs[i]) begin
            exp_t e;
            repeat (10) @(negedge clk);
            rgb = vecs[i].rgb;
            rgb_valid = 1'b1;
            e.r = vecs[i].er; e.g = vecs[i].eg; e.b = vecs[i].eb;
            e.tag = $sformatf("vec%0d", i);
            exp_q.push_back(e);
            @(negedge clk);
            rgb_valid = 1'b0;
            chk($sformatf("vec%0d_pending_set", i), int'(pend), 1);
            wait_ps(600, w);
            chk($sformatf("vec%0d_pending_clr", i), int'(pend), 0);
            measure(-1, '0, -1, '0);
        end

        // Two loads inside one period: current period keeps 008040,
        // the next one shows only the last load.
        push_exp(24'h008040, 1, "keep_old");
        measure(5, 24'h000010, 20, 24'h000020);
        chk("keep_old_pending_end", last_pend, 0);
        push_exp(24'h000020, 1, "last_wins");
        measure(-1, '0, -1, '0);

        // Load exactly on the boundary cycle (pwm_cnt==255): bypass.
        push_exp(24'h000020, 1, "pre_bypass");
        measure(255, 24'h0A0000, -1, '0);
        chk("bypass_pending", last_pend, 0);
        push_exp(24'h0A0000, 1, "bypass");
        measure(-1, '0, -1, '0);

        // Reset mid-period with a colour active and another pending.
        repeat (5) @(negedge clk);
        rgb = 24'h00FF00;
        rgb_valid = 1'b1;
        @(negedge clk);
        rgb_valid = 1'b0;
        chk("pre_reset_pending", int'(pend), 1);
        repeat (90) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("post_reset_outs", int'({pr, pg, pb, ps, pend}), 0);
        hi = 0;
        first_ps = 0;
        for (int j = 1; j <= 300 && first_ps == 0; j++) begin
            @(negedge clk);
            hi += int'(pr) + int'(pg) + int'(pb) + int'(pend);
            if (ps) first_ps = j;
        end
        chk("post_reset_first_ps", first_ps, 256);
        chk("post_reset_outs_low", hi, 0);
        push_exp(24'h000000, 1, "pend_discarded");
        measure(-1, '0, -1, '0);

        // PRESCALE=4 instance.
        sel = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        rgb = 24'h808080;
        rgb_valid = 1'b1;
        @(negedge clk);
        rgb_valid = 1'b0;
        chk("p4_pending_set", int'(pend), 1);
        push_exp(24'h808080, 4, "p4_a");
        wait_ps(2000, w);
        chk("p4_first_ps", w + 1, 1024);
        chk("p4_pending_clr", int'(pend), 0);
        measure(-1, '0, -1, '0);
        push_exp(24'h808080, 4, "p4_b");
        measure(-1, '0, -1, '0);

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/rgb_pwm_driver.md
# rgb_pwm_driver

Three-channel PWM LED driver that sits directly downstream of the RGB colour converter. It accepts the converter's 24-bit `rgb` word (R in [23:16], G in [15:8], B in [7:0]) and drives three PWM outputs to a tri-colour LED, with duty cycle proportional to each 8-bit channel value. New colour values are double-buffered and applied only at PWM period boundaries, so the LED never shows a glitched partial period.

## Interface
- `PRESCALE`, default 4: clocks per PWM counter step. Legal range 1..65535. Period = 256 × `PRESCALE` clocks.
- `clk`  in  1  system clock.
- `rst`  in  1  reset, **synchronous, active-high**.
- `rgb`  in  24  colour word from the converter.
- `rgb_valid`  in  1  load strobe; `rgb` is sampled on any rising `clk` edge where this is high.
- `pwm_r`, `pwm_g`, `pwm_b`  out  1 each  PWM outputs, registered.
- `period_start`  out  1  one-cycle pulse at the first clock of each PWM period, registered.
- `pending`  out  1  high while a loaded colour is waiting for the next period boundary.

## Operation
- Prescaler `presc_cnt` counts 0..`PRESCALE`-1 and wraps. `tick` = (`presc_cnt` == `PRESCALE`-1). When `PRESCALE`=1, `tick` is constantly high.
- `pwm_cnt` is 8 bits and increments on `tick`, wrapping 255→0.
- `boundary` = `tick` && `pwm_cnt` == 255.
- Shadow register `pend_rgb` and flag `pend_v`:
  - `rgb_valid` && !`boundary`: `pend_rgb` ← `rgb`, `pend_v` ← 1. A later load before the boundary overwrites it (last wins).
  - `boundary` && `rgb_valid`: `active` ← `rgb` (bypass) and `pend_v` ← 0.
  - `boundary` && !`rgb_valid` && `pend_v`: `active` ← `pend_rgb`, `pend_v` ← 0.
  - `boundary` with nothing pending: `active` is unchanged.
- Per channel, with duty `d` taken from `active`: output ← (`d` == 8'hFF) || (`pwm_cnt` < `d`).
  - `d`=0 gives constantly low.
  - `d`=1..254 gives `d`×`PRESCALE` high clocks per period.
  - `d`=255 gives constantly high (full-on special case).
- `period_start` ← `boundary`.
- `pending` = `pend_v`.

## Timing
- Reset values: `presc_cnt`=0, `pwm_cnt`=0, `active`=0, `pend_rgb`=0, `pend_v`=0. All outputs are 0 on the cycle after `rst` is sampled high.
- Reset asserted mid-period discards any pending colour. The first boundary after reset release occurs 256×`PRESCALE` clocks later.
- `rgb_valid` to `pending` high: 1 clock.
- Output latency: outputs are registered from current `pwm_cnt` and `active`. The output for counter value `n` appears one clock after `pwm_cnt`=`n`.
- New colour visible on the outputs: at most one full period plus 1 clock after `rgb_valid`.
- `period_start` is high in the same cycle that `pwm_cnt` first reads 0 of the new period. It does not pulse during reset.
- No backpressure: `rgb_valid` may be asserted on any cycle, including continuously.

## Structure
- Shared package/include `rgb_pkg` holds:
  - the channel slice constants (`R_MSB`=23, `G_MSB`=15, `B_MSB`=7);
  - the duty width `DUTY_W`=8;
  - `DUTY_FULL`=8'hFF.
- Sub-module `pwm_channel`: inputs `clk`, `rst`, `cnt`[7:0], `duty`[7:0]; output `pwm` (compare plus output register). It is instantiated three times.
- Prescaler, `pwm_cnt`, shadow logic and `period_start` live in `rgb_pwm_driver`.

## Test plan
All scenarios use `PRESCALE`=1 unless stated.

- Reset, then one-cycle `rgb_valid` with `rgb`=24'hFF0000 → `pending` goes high. After the first `period_start`:
  - `pwm_r` is constantly high;
  - `pwm_g` and `pwm_b` are constantly low;
  - `pending` returns to 0.
- Load `rgb`=24'h008040 → over each 256-clock period, `pwm_g` is high for 128 clocks, `pwm_b` for 64 clocks, and `pwm_r` for 0 clocks. High time starts 1 clock after `period_start`.
- Mid-period, load 24'h000010 and then 24'h000020 → the current period keeps the old duty. The next period gives `pwm_b` 32 high clocks (last wins).
- Assert `rgb_valid` exactly on the `boundary` cycle with 24'h0A0000 → `pwm_r` is high for 10 clocks in that very period, and `pending` stays 0.
- Assert `rst` for 1 cycle mid-period with a colour active and another pending → all outputs and `pending` are 0 on the next cycle. Outputs stay 0, because `active` was cleared, until a new load takes effect. The next `period_start` comes 256 clocks after reset release.
- `PRESCALE`=4 with load 24'h808080 → `period_start` pulses every 1024 clocks, and each output is high for 512 clocks per period.
